// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The master side issues operations; the slave side (hilo_muldiv) returns busy/we and the HI/LO result.
interface hilo_muldiv_if #(
   parameter int DATA_W = 32
) ();
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] hi_cur;
   logic [DATA_W-1:0] lo_cur;
   logic              cancel;
   logic              busy;
   logic              we;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;

   modport master (
      output start, op, opa, opb, hi_cur, lo_cur, cancel,
      input  busy, we, hi_o, lo_o
   );

   modport slave (
      input  start, op, opa, opb, hi_cur, lo_cur, cancel,
      output busy, we, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit feeding the HILO write port: single-cycle multiply, restoring divider.
// Define MULDIV_MADD_EN to enable MADD/MSUB (accumulate into the forwarded HI/LO); otherwise they decode as NOP.
module hilo_muldiv #(
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   hilo_muldiv_if.slave bus
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
`ifdef MULDIV_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b100;
   localparam logic [2:0] OP_MSUB  = 3'b101;
`endif

   localparam int             CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   function automatic logic is_mul_op(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
      return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) || (o == OP_MSUB);
`else
      return (o == OP_MULT) || (o == OP_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input logic [2:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v, input logic sgn);
      return (sgn && v[DATA_W-1]) ? -v : v;
   endfunction

   // Negating 0x8000_0000 yields itself, which gives the required wrap for MIN / -1.
   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
`ifdef MULDIV_MADD_EN
   logic signed [2*DATA_W-1:0] acc_q, acc_d;
`endif

   logic                       accept;
   logic                       sgn_mul;
   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] b_ext;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W-1:0] mul_res;

   logic                       div_signed;
   logic [DATA_W-1:0]          divisor;
   logic [DATA_W:0]            shifted;
   logic                       qbit;
   logic [DATA_W-1:0]          rem_next;
   logic [DATA_W-1:0]          quo_next;

   assign accept = (state_q == S_IDLE) && bus.start && !bus.cancel;

   // Extending to 2*DATA_W lets one signed multiplier serve both MULT and MULTU.
   always_comb begin
      sgn_mul = (op_q != OP_MULTU);
      a_ext   = signed'({{DATA_W{sgn_mul & a_q[DATA_W-1]}}, a_q});
      b_ext   = signed'({{DATA_W{sgn_mul & b_q[DATA_W-1]}}, b_q});
      prod    = a_ext * b_ext;
      mul_res = prod;
`ifdef MULDIV_MADD_EN
      if (op_q == OP_MADD) begin
         mul_res = acc_q + prod;
      end else if (op_q == OP_MSUB) begin
         mul_res = acc_q - prod;
      end
`endif
   end

   // Restoring step: the partial remainder always stays below the divisor, so DATA_W bits suffice.
   always_comb begin
      div_signed = (op_q == OP_DIV);
      divisor    = abs_mag(b_q, div_signed);
      shifted    = {rem_q, quo_q[DATA_W-1]};
      qbit       = (shifted >= {1'b0, divisor});
      rem_next   = qbit ? (shifted[DATA_W-1:0] - divisor) : shifted[DATA_W-1:0];
      quo_next   = {quo_q[DATA_W-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
`ifdef MULDIV_MADD_EN
      acc_d   = acc_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = bus.op;
               a_d   = bus.opa;
               b_d   = bus.opb;
               cnt_d = '0;
               rem_d = '0;
               quo_d = abs_mag(bus.opa, bus.op == OP_DIV);
`ifdef MULDIV_MADD_EN
               acc_d = signed'({bus.hi_cur, bus.lo_cur});
`endif
               if (is_mul_op(bus.op)) begin
                  state_d = S_MUL;
               end else if (is_div_op(bus.op)) begin
                  if (bus.opb == '0) begin
                     state_d = S_DONE;
                     hi_d    = bus.opa;
                     lo_d    = '1;
                  end else begin
                     state_d = S_DIV;
                  end
               end
            end
         end
         S_MUL: begin
            state_d = S_DONE;
            {hi_d, lo_d} = mul_res;
         end
         S_DIV: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               hi_d    = apply_sign(rem_next, div_signed & a_q[DATA_W-1]);
               lo_d    = apply_sign(quo_next, div_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]));
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A flush drops the operation in flight and leaves the last result visible.
      if ((state_q != S_IDLE) && bus.cancel) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
`ifdef MULDIV_MADD_EN
      acc_q <= acc_d;
`endif
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.we   = (state_q == S_DONE) && !bus.cancel;
   assign bus.hi_o = hi_q;
   assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: reset, MULT/MULTU, DIV/DIVU, divide-by-zero, cancel and MADD/MSUB decode.
module tb_hilo_muldiv;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   int   fails;
   int   cyc;
   int   nwe;

   hilo_muldiv_if #(.DATA_W(32)) bus ();

   hilo_muldiv #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.op    = o;
      bus.opa   = a;
      bus.opb   = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Cycles from the start request until we is seen; stops at limit.
   task automatic wait_we(input int limit, output int c);
      c = 1;
      while (bus.we !== 1'b1 && c < limit) begin
         tick();
         c++;
      end
   endtask

   task automatic count_we(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         tick();
         if (bus.we === 1'b1) cnt++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      int c;
      issue(o, a, b);
      wait_we(lat + 5, c);
      chk({tag, "_lat"}, 32'(c), 32'(lat));
      chk({tag, "_hi"}, bus.hi_o, hi_exp);
      chk({tag, "_lo"}, bus.lo_o, lo_exp);
      tick();
      chk({tag, "_we_1cyc"}, 32'(bus.we), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      fails     = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'b111;
      bus.opa   = '0;
      bus.opb   = '0;
      bus.hi_cur = '0;
      bus.lo_cur = '0;
      bus.cancel = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_hi", bus.hi_o, 32'd0);
      chk("rst_lo", bus.lo_o, 32'd0);
      rst = 1'b1;
      tick();

      run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("mult_big", 3'b000, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'h0000_0000);

      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", 3'b011, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("div_nd", 3'b010, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
      run_op("divu_z", 3'b011, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
      run_op("div_z", 3'b010, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

      // Cancel mid-divide with a competing start on the same edge.
      issue(3'b010, 32'd100, 32'd7);
      repeat (9) tick();
      chk("div_busy_mid", 32'(bus.busy), 32'd1);
      bus.cancel = 1'b1;
      bus.start  = 1'b1;
      bus.op     = 3'b000;
      bus.opa    = 32'd2;
      bus.opb    = 32'd2;
      tick();
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      chk("cancel_we", 32'(bus.we), 32'd0);
      count_we(40, nwe);
      chk("cancel_no_late_we", 32'(nwe), 32'd0);
      chk("cancel_hi_hold", bus.hi_o, 32'd0);
      chk("cancel_lo_hold", bus.lo_o, 32'h8000_0000);

      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      tick();
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      chk("idle_cancel_busy", 32'(bus.busy), 32'd0);
      count_we(5, nwe);
      chk("idle_cancel_no_we", 32'(nwe), 32'd0);

      issue(3'b000, 32'd3, 32'd4);
      tick();
      chk("done_we_pre", 32'(bus.we), 32'd1);
      bus.cancel = 1'b1;
      #1;
      chk("done_cancel_we", 32'(bus.we), 32'd0);
      tick();
      bus.cancel = 1'b0;
      #1;
      chk("done_cancel_idle", 32'(bus.busy), 32'd0);
      count_we(3, nwe);
      chk("done_cancel_no_we", 32'(nwe), 32'd0);

      // Reset held mid-divide.
      issue(3'b011, 32'd100, 32'd7);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_we", 32'(bus.we), 32'd0);
      chk("midrst_hi", bus.hi_o, 32'd0);
      chk("midrst_lo", bus.lo_o, 32'd0);
      tick();
      rst = 1'b1;
      count_we(40, nwe);
      chk("midrst_no_late_we", 32'(nwe), 32'd0);

`ifdef MULDIV_MADD_EN
      bus.hi_cur = 32'd0;
      bus.lo_cur = 32'd10;
      run_op("msub", 3'b101, 32'd3, 32'd4, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("madd", 3'b100, 32'd3, 32'd4, 2, 32'd0, 32'd22);
      bus.hi_cur = 32'hFFFF_FFFF;
      bus.lo_cur = 32'hFFFF_FFFF;
      run_op("madd_wrap", 3'b100, 32'd1, 32'd1, 2, 32'd0, 32'd0);
`else
      issue(3'b100, 32'd3, 32'd4);
      chk("madd_nop_busy", 32'(bus.busy), 32'd0);
      count_we(5, nwe);
      chk("madd_nop_no_we", 32'(nwe), 32'd0);
      issue(3'b101, 32'd3, 32'd4);
      chk("msub_nop_busy", 32'(bus.busy), 32'd0);
      count_we(5, nwe);
      chk("msub_nop_no_we", 32'(nwe), 32'd0);
`endif

      issue(3'b111, 32'd3, 32'd4);
      chk("nop_busy", 32'(bus.busy), 32'd0);
      count_we(3, nwe);
      chk("nop_no_we", 32'(nwe), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
